mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 20 ++
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Memory-side bus of mem_arbiter: one request strobe, held attributes, one response strobe.
interface mem_arbiter_if;
    logic        mem_ready;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_ready, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_valid, mem_rdata
    );

    modport slave (
        input  mem_ready, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_valid, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-outstanding memory bus with a WAIT timeout.
// Define ROUND_ROBIN_EN for alternating priority; otherwise the data port always wins.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 f_req,
    input  logic [31:0]          f_addr,
    output logic                 f_valid,
    output logic [31:0]          f_rdata,
    input  logic                 d_req,
    input  logic [31:0]          d_addr,
    input  logic [31:0]          d_wdata,
    input  logic [3:0]           d_wstrb,
    output logic                 d_valid,
    output logic [31:0]          d_rdata,
    mem_arbiter_if.master        mem,
    output logic                 bus_error
);

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic        pend_f_q, pend_f_d, pend_d_q, pend_d_d;
    logic [31:0] f_addr_q, f_addr_d, d_addr_q, d_addr_d, d_wdata_q, d_wdata_d;
    logic [3:0]  d_wstrb_q, d_wstrb_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mem_ready_q, mem_ready_d, mem_instr_q, mem_instr_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        f_valid_q, f_valid_d, d_valid_q, d_valid_d;
    logic [31:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
    logic        bus_error_q, bus_error_d;
`ifdef ROUND_ROBIN_EN
    logic        rr_q, rr_d;  // 1: fetch favoured on the next contested grant
`endif
    logic        pick_data;
    logic        done;
    logic [31:0] resp;

    always_comb begin
        state_d     = state_q;
        pend_f_d    = pend_f_q;
        pend_d_d    = pend_d_q;
        f_addr_d    = f_addr_q;
        d_addr_d    = d_addr_q;
        d_wdata_d   = d_wdata_q;
        d_wstrb_d   = d_wstrb_q;
        cnt_d       = cnt_q;
        mem_ready_d = 1'b0;
        mem_instr_d = mem_instr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        f_valid_d   = 1'b0;
        d_valid_d   = 1'b0;
        f_rdata_d   = f_rdata_q;
        d_rdata_d   = d_rdata_q;
        bus_error_d = bus_error_q;
        pick_data   = 1'b0;
        done        = 1'b0;
        resp        = '0;
`ifdef ROUND_ROBIN_EN
        rr_d        = rr_q;
`endif

        // A port with a pending or in-flight request ignores further strobes.
        if (f_req && !pend_f_q) begin
            pend_f_d = 1'b1;
            f_addr_d = f_addr;
        end
        if (d_req && !pend_d_q) begin
            pend_d_d  = 1'b1;
            d_addr_d  = d_addr;
            d_wdata_d = d_wdata;
            d_wstrb_d = d_wstrb;
        end

`ifdef ROUND_ROBIN_EN
        pick_data = pend_d_d & (~pend_f_d | ~rr_q);
`else
        pick_data = pend_d_d;
`endif

        unique case (state_q)
            StIdle: begin
                if (pend_f_d || pend_d_d) begin
                    state_d     = StWait;
                    mem_ready_d = 1'b1;
                    cnt_d       = '0;
                    mem_instr_d = ~pick_data;
                    if (pick_data) begin
                        mem_addr_d  = d_addr_d;
                        mem_wdata_d = d_wdata_d;
                        mem_wstrb_d = d_wstrb_d;
                    end else begin
                        mem_addr_d  = f_addr_d;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end
`ifdef ROUND_ROBIN_EN
                    rr_d = pick_data;
`endif
                end
            end
            StWait: begin
                if (mem.mem_valid) begin
                    done = 1'b1;
                    resp = mem.mem_rdata;
                end else if (cnt_q == TimeoutLast) begin
                    done        = 1'b1;
                    bus_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (done) begin
                    state_d = StIdle;
                    if (mem_instr_q) begin
                        f_valid_d = 1'b1;
                        f_rdata_d = resp;
                        pend_f_d  = 1'b0;
                    end else begin
                        d_valid_d = 1'b1;
                        d_rdata_d = resp;
                        pend_d_d  = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            pend_f_q    <= 1'b0;
            pend_d_q    <= 1'b0;
            f_addr_q    <= '0;
            d_addr_q    <= '0;
            d_wdata_q   <= '0;
            d_wstrb_q   <= '0;
            cnt_q       <= '0;
            mem_ready_q <= 1'b0;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            f_valid_q   <= 1'b0;
            d_valid_q   <= 1'b0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
            bus_error_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pend_f_q    <= pend_f_d;
            pend_d_q    <= pend_d_d;
            f_addr_q    <= f_addr_d;
            d_addr_q    <= d_addr_d;
            d_wdata_q   <= d_wdata_d;
            d_wstrb_q   <= d_wstrb_d;
            cnt_q       <= cnt_d;
            mem_ready_q <= mem_ready_d;
            mem_instr_q <= mem_instr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            f_valid_q   <= f_valid_d;
            d_valid_q   <= d_valid_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
            bus_error_q <= bus_error_d;
`ifdef ROUND_ROBIN_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign mem.mem_ready = mem_ready_q;
    assign mem.mem_instr = mem_instr_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_wstrb = mem_wstrb_q;
    assign f_valid       = f_valid_q;
    assign f_rdata       = f_rdata_q;
    assign d_valid       = d_valid_q;
    assign d_rdata       = d_rdata_q;
    assign bus_error     = bus_error_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned TO = 4;

    typedef struct {
        bit          fr;
        logic [31:0] fa;
        bit          dr;
        logic [31:0] da;
        logic [31:0] dw;
        logic [3:0]  ds;
        bit          mv;
        logic [31:0] md;
    } stim_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, d_req;
    logic [31:0] f_addr, d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        f_valid, d_valid, bus_error;
    logic [31:0] f_rdata, d_rdata;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_valid   (f_valid),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .mem       (bus),
        .bus_error (bus_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: port 0 = fetch, port 1 = data.
    bit          pend [2];
    logic [31:0] paddr [2];
    logic [31:0] pwdata [2];
    logic [3:0]  pwstrb [2];
    logic [31:0] prdata [2];
    bit          pvalid [2];
    bit          busy;
    int          cur, last, age;
    bit          e_ready, e_instr, e_err;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            pend[p]   = 0;
            prdata[p] = '0;
            pvalid[p] = 0;
        end
        busy    = 0;
        last    = 0;  // as if fetch went last, so data is favoured first
        age     = 0;
        e_ready = 0;
        e_instr = 0;
        e_err   = 0;
        e_addr  = '0;
        e_wdata = '0;
        e_wstrb = '0;
    endtask

    task automatic model_step();
        e_ready   = 0;
        pvalid[0] = 0;
        pvalid[1] = 0;
        if (f_req && !pend[0]) begin
            pend[0] = 1; paddr[0] = f_addr; pwdata[0] = '0; pwstrb[0] = '0;
        end
        if (d_req && !pend[1]) begin
            pend[1] = 1; paddr[1] = d_addr; pwdata[1] = d_wdata; pwstrb[1] = d_wstrb;
        end
        if (busy) begin
            age++;
            if (bus.mem_valid || age == int'(TO)) begin
                if (!bus.mem_valid) e_err = 1;
                prdata[cur] = bus.mem_valid ? bus.mem_rdata : 32'h0;
                pvalid[cur] = 1;
                pend[cur]   = 0;
                busy        = 0;
            end
        end else if (pend[0] || pend[1]) begin
            if (pend[0] && pend[1]) begin
`ifdef ROUND_ROBIN_EN
                cur = 1 - last;
`else
                cur = 1;
`endif
            end else begin
                cur = pend[1] ? 1 : 0;
            end
            last    = cur;
            busy    = 1;
            age     = 0;
            e_ready = 1;
            e_instr = (cur == 0);
            e_addr  = paddr[cur];
            e_wdata = pwdata[cur];
            e_wstrb = pwstrb[cur];
        end
    endtask

    task automatic check_all();
        check_eq("mem_ready", 32'(bus.mem_ready), 32'(e_ready));
        check_eq("mem_instr", 32'(bus.mem_instr), 32'(e_instr));
        check_eq("mem_addr",  bus.mem_addr,       e_addr);
        check_eq("mem_wdata", bus.mem_wdata,      e_wdata);
        check_eq("mem_wstrb", 32'(bus.mem_wstrb), 32'(e_wstrb));
        check_eq("f_valid",   32'(f_valid),       32'(pvalid[0]));
        check_eq("f_rdata",   f_rdata,            prdata[0]);
        check_eq("d_valid",   32'(d_valid),       32'(pvalid[1]));
        check_eq("d_rdata",   d_rdata,            prdata[1]);
        check_eq("bus_error", 32'(bus_error),     32'(e_err));
    endtask

    function automatic stim_t mk(bit fr, logic [31:0] fa, bit dr, logic [31:0] da,
                                 logic [31:0] dw, logic [3:0] ds, bit mv, logic [31:0] md);
        stim_t s;
        s.fr = fr; s.fa = fa; s.dr = dr; s.da = da;
        s.dw = dw; s.ds = ds; s.mv = mv; s.md = md;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        f_req         = s.fr;
        f_addr        = s.fa;
        d_req         = s.dr;
        d_addr        = s.da;
        d_wdata       = s.dw;
        d_wstrb       = s.ds;
        bus.mem_valid = s.mv;
        bus.mem_rdata = s.md;
    endtask

    stim_t dir [13];
    stim_t s;

    initial begin
        for (int i = 0; i < 13; i++) dir[i] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        dir[0] = mk(1, 32'h100, 0, 0, 0, 0, 0, 0);                       // lone fetch
        dir[2] = mk(0, 0, 0, 0, 0, 0, 1, 32'h13);                        // its response
        dir[3] = mk(0, 0, 0, 0, 0, 0, 1, 32'h55);                        // stray valid in idle
        dir[4] = mk(1, 32'h200, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 0);  // contested pair
        dir[5] = mk(0, 0, 1, 32'h3000, 32'h1, 4'h1, 0, 0);               // duplicate data strobe
        dir[6] = mk(0, 0, 0, 0, 0, 0, 1, 32'h11111111);                  // data response
        // fetch then issues and is left to time out

        reset = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 13 || (cyc > 13 && $urandom_range(0, 99) == 0)) begin
                reset = 1'b0;
                drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
                #1;
                model_reset();
                check_all();
                @(posedge clk);
                @(negedge clk);
                reset = 1'b1;
                drive(mk(0, 0, 0, 0, 0, 0, 1, $urandom()));  // late response after release
            end else if (cyc < 13) begin
                drive(dir[cyc]);
            end else begin
                s.fr = ($urandom_range(0, 99) < 30);
                s.fa = $urandom();
                s.dr = ($urandom_range(0, 99) < 30);
                s.da = $urandom();
                s.dw = $urandom();
                s.ds = 4'($urandom_range(0, 15));
                s.mv = ($urandom_range(0, 99) < 30);
                s.md = $urandom();
                drive(s);
            end
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
